// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: recovers sync timing, pixel coordinates and colour from the TinyVGA PMOD bus and locks to the expected timing.
// Define VGA_RX_SIG_EN to add a CRC-16-CCITT signature over each fully locked frame's active pixels.
module vga_rx_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_ACT_START = 34,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  rgb,
  output logic        locked,
  output logic        frame_done,
  output logic [9:0]  h_total_meas,
  output logic [6:0]  h_sync_meas,
  output logic [9:0]  v_total_meas,
  output logic        err,
  output logic [15:0] frame_sig
);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t state, state_nxt;
  logic [7:0] in_q;
  logic hs_q, vs_q, hs_d, vs_d, hs_fall, hs_rise, vs_fall, close;
  logic [9:0] h_reg, h_cnt, v_cnt;
  logic seen_hf, seen_close, vs_pend, frame_bad;
  logic len_bad, wid_bad, vtot_bad, sat_bad, any_bad, good_frame, pv;
  logic [1:0] good_cnt, good_nxt;
  assign hs_q = in_q[7];
  assign vs_q = in_q[3];
  assign locked = state == LOCKED;
  always_comb begin
    hs_fall = hs_d & ~hs_q;
    hs_rise = ~hs_d & hs_q;
    vs_fall = vs_d & ~vs_q;
    close = hs_fall & vs_pend;
    h_cnt = hs_fall ? '0 : (&h_reg ? h_reg : h_reg + 10'd1);
    len_bad = hs_fall & seen_hf & (h_reg + 10'd1 != 10'(H_TOTAL));
    wid_bad = hs_rise & seen_hf & (h_cnt != 10'(H_SYNC));
    vtot_bad = close & (v_cnt + 10'd1 != 10'(V_TOTAL));
    sat_bad = &h_reg | &v_cnt;
    any_bad = len_bad | wid_bad | vtot_bad | sat_bad;
    good_frame = ~(frame_bad | any_bad);
    pv = h_cnt >= 10'(H_ACT_START) && h_cnt < 10'(H_ACT_START + H_ACTIVE) &&
         v_cnt >= 10'(V_ACT_START) && v_cnt < 10'(V_ACT_START + V_ACTIVE) && locked;
    state_nxt = state;
    good_nxt = good_cnt;
    case (state)
      SEARCH: if (vs_fall) begin
        state_nxt = MEASURE;
        good_nxt = '0;
      end
      MEASURE: if (close) begin
        good_nxt = good_frame ? good_cnt + 2'd1 : '0;
        state_nxt = (good_frame && good_cnt + 2'd1 == 2'(LOCK_FRAMES)) ? LOCKED : MEASURE;
      end
      LOCKED: if (any_bad) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q <= 8'h88;
      hs_d <= 1'b1;
      vs_d <= 1'b1;
      h_reg <= '0;
      v_cnt <= '0;
      seen_hf <= 1'b0;
      seen_close <= 1'b0;
      vs_pend <= 1'b0;
      frame_bad <= 1'b1;
      good_cnt <= '0;
      state <= SEARCH;
      err <= 1'b0;
      frame_done <= 1'b0;
      h_total_meas <= '0;
      h_sync_meas <= '0;
      v_total_meas <= '0;
      pix_valid <= 1'b0;
      pix_x <= '0;
      pix_y <= '0;
      rgb <= '0;
    end else begin
      in_q <= vga_in;
      hs_d <= hs_q;
      vs_d <= vs_q;
      h_reg <= h_cnt;
      if (hs_fall) begin
        seen_hf <= 1'b1;
        if (seen_hf) h_total_meas <= h_reg + 10'd1;
        v_cnt <= vs_pend ? '0 : (&v_cnt ? v_cnt : v_cnt + 10'd1);
        if (vs_pend) seen_close <= 1'b1;
        if (vs_pend && seen_close) v_total_meas <= v_cnt + 10'd1;
      end
      if (hs_rise && seen_hf) h_sync_meas <= |h_cnt[9:7] ? 7'h7f : h_cnt[6:0];
      // a line closing on the vsync-fall clock still belongs to the ending frame
      vs_pend <= vs_fall | (vs_pend & ~hs_fall);
      frame_bad <= (state == SEARCH) | (~close & (frame_bad | any_bad));
      good_cnt <= good_nxt;
      state <= state_nxt;
      err <= err | (locked & any_bad);
      frame_done <= vs_fall;
      pix_valid <= pv;
      pix_x <= pv ? h_cnt - 10'(H_ACT_START) : '0;
      pix_y <= pv ? v_cnt - 10'(V_ACT_START) : '0;
      rgb <= pv ? {in_q[0], in_q[4], in_q[1], in_q[5], in_q[2], in_q[6]} : '0;
    end
  end
`ifdef VGA_RX_SIG_EN
  logic [15:0] crc, crc_nxt;
  logic lock_all;
  always_comb begin
    crc_nxt = crc;
    for (int i = 5; i >= 0; i--)
      crc_nxt = {crc_nxt[14:0], 1'b0} ^ ((crc_nxt[15] ^ rgb[i]) ? 16'h1021 : 16'h0000);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc <= 16'hffff;
      lock_all <= 1'b0;
      frame_sig <= '0;
    end else if (frame_done) begin
      crc <= 16'hffff;
      lock_all <= locked;
      if (lock_all && locked) frame_sig <= crc;
    end else begin
      lock_all <= lock_all & locked;
      if (pix_valid) crc <= crc_nxt;
    end
  end
`else
  assign frame_sig = '0;
`endif
endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor: directed checks of vga_rx_monitor using a scaled-down 40x12 timing so each frame is 480 clocks.
module tb_vga_rx_monitor;
  localparam int HT = 40, HS = 6, HA0 = 10, HA = 24, VT = 12, VA0 = 3, VA = 6;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] vga_in = 8'h88;
  logic pix_valid, locked, frame_done, err;
  logic [9:0] pix_x, pix_y, h_total_meas, v_total_meas;
  logic [6:0] h_sync_meas;
  logic [5:0] rgb;
  logic [15:0] frame_sig;
  vga_rx_monitor #(.H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HA0), .H_ACTIVE(HA),
                   .V_TOTAL(VT), .V_ACT_START(VA0), .V_ACTIVE(VA), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .vga_in(vga_in), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .rgb(rgb), .locked(locked), .frame_done(frame_done),
    .h_total_meas(h_total_meas), .h_sync_meas(h_sync_meas), .v_total_meas(v_total_meas),
    .err(err), .frame_sig(frame_sig));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    int nfr; int hsw; int stretch; int pmode;
    int locked; int err; int ht; int hs; int vt;
  } vec_t;
  vec_t tab[9];
  int nvec = 0, nfail = 0;
  int hsw = HS, stretch = -1, pmode = 0;
  int col_drv_cyc = -1, fall_drv_cyc = -1, lock_fall_cyc = -1;
  int valid_cnt = 0, nz_cnt = 0, nz_x = 0, nz_y = 0, nz_rgb = 0, nz_cyc = 0, zero_bad = 0;
  logic prev_locked = 1'b0;
  always @(negedge clk) begin
    if (prev_locked && !locked) lock_fall_cyc = cyc;
    prev_locked = locked;
    if (pix_valid) begin
      valid_cnt++;
      if (rgb != 0) begin
        nz_cnt++;
        nz_x = int'(pix_x);
        nz_y = int'(pix_y);
        nz_rgb = int'(rgb);
        nz_cyc = cyc;
      end
    end else if (pix_x != 0 || pix_y != 0 || rgb != 0) zero_bad++;
  end
  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // colour c is {r1,r0,g1,g0,b1,b0}; bus is {hs,b0,g0,r0,vs,b1,g1,r1}
  task automatic drive(input logic hs, input logic vs, input logic [5:0] c);
    @(negedge clk);
    vga_in = {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
  endtask
  task automatic run_frames(input int n);
    logic [5:0] c;
    for (int f = 0; f < n; f++)
      for (int l = 0; l < VT; l++)
        for (int h = 0; h < ((l == stretch) ? HT + 1 : HT); h++) begin
          c = '0;
          if (l >= VA0 + 1 && l < VA0 + 1 + VA && h >= HA0 && h < HA0 + HA) begin
            if (pmode == 1 && h == HA0 && l == VA0 + 1) c = 6'b110100;
            if (pmode == 2 && h == HA0 + 3 && l == VA0 + 3) c = 6'h3f;
          end
          drive(h >= hsw, l >= 2, c);
          if (c != 0) col_drv_cyc = cyc;
          if (stretch >= 0 && l == stretch + 1 && h == 0) fall_drv_cyc = cyc;
        end
  endtask
  function automatic logic [15:0] sig_model(input int white);
    logic [15:0] crc = 16'hffff;
    logic [5:0] d;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++) begin
        d = (white != 0 && x == 3 && y == 2) ? 6'h3f : 6'h00;
        for (int i = 5; i >= 0; i--)
          crc = {crc[14:0], 1'b0} ^ ((crc[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      end
`ifdef VGA_RX_SIG_EN
    return crc;
`else
    return (crc & 16'h0);
`endif
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vga_in = 8'h88;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) drive(1'b1, 1'b1, 6'h00);
  endtask
  task automatic apply(input int i);
    vec_t v = tab[i];
    hsw = v.hsw;
    stretch = v.stretch;
    pmode = v.pmode;
    valid_cnt = 0;
    nz_cnt = 0;
    lock_fall_cyc = -1;
    run_frames(v.nfr);
    stretch = -1;
    chk($sformatf("v%0d locked", i), int'(locked), v.locked);
    chk($sformatf("v%0d err", i), int'(err), v.err);
    chk($sformatf("v%0d h_total_meas", i), int'(h_total_meas), v.ht);
    chk($sformatf("v%0d h_sync_meas", i), int'(h_sync_meas), v.hs);
    chk($sformatf("v%0d v_total_meas", i), int'(v_total_meas), v.vt);
    if (v.pmode == 1) begin
      chk("pixel count", valid_cnt, HA * VA);
      chk("nonzero pixels", nz_cnt, 1);
      chk("pix_x of colour", nz_x, 0);
      chk("pix_y of colour", nz_y, 0);
      chk("rgb of colour", nz_rgb, 6'b110100);
      chk("colour latency", nz_cyc - col_drv_cyc, 2);
    end
    if (v.stretch >= 0) chk("lock drop latency", lock_fall_cyc - fall_drv_cyc, 2);
  endtask
  logic [15:0] s1, s2, s3, s4;
  initial begin
    tab[0] = '{2, 6, -1, 0, 0, 0, 40, 6, 12};
    tab[1] = '{1, 6, -1, 0, 1, 0, 40, 6, 12};
    tab[2] = '{1, 6, -1, 1, 1, 0, 40, 6, 12};
    tab[3] = '{1, 6, 5, 0, 0, 1, 40, 6, 12};
    tab[4] = '{2, 6, -1, 0, 0, 1, 40, 6, 12};
    tab[5] = '{1, 6, -1, 0, 1, 1, 40, 6, 12};
    tab[6] = '{3, 5, -1, 0, 0, 0, 40, 5, 12};
    tab[7] = '{2, 6, -1, 0, 0, 0, 40, 6, 12};
    tab[8] = '{1, 6, -1, 0, 1, 0, 40, 6, 12};
    do_reset();
    chk("reset locked", int'(locked), 0);
    chk("reset err", int'(err), 0);
    chk("reset h_total_meas", int'(h_total_meas), 0);
    chk("reset v_total_meas", int'(v_total_meas), 0);
    chk("reset frame_sig", int'(frame_sig), 0);
    for (int i = 0; i < 6; i++) apply(i);
    for (int h = 0; h < 15; h++) drive(h >= HS, 1'b1, 6'h00);
    chk("pre-reset err", int'(err), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid reset locked", int'(locked), 0);
    chk("mid reset err", int'(err), 0);
    chk("mid reset h_total_meas", int'(h_total_meas), 0);
    chk("mid reset h_sync_meas", int'(h_sync_meas), 0);
    chk("mid reset v_total_meas", int'(v_total_meas), 0);
    chk("mid reset pix_valid", int'(pix_valid), 0);
    chk("mid reset frame_done", int'(frame_done), 0);
    rst_n = 1'b1;
    vga_in = 8'h88;
    repeat (3) drive(1'b1, 1'b1, 6'h00);
    for (int i = 6; i < 9; i++) apply(i);
    pmode = 0;
    run_frames(2);
    s1 = frame_sig;
    run_frames(1);
    s2 = frame_sig;
    pmode = 2;
    run_frames(2);
    s3 = frame_sig;
    run_frames(1);
    s4 = frame_sig;
    pmode = 0;
    chk("sig black", int'(s1), int'(sig_model(0)));
    chk("sig black repeat", int'(s2), int'(sig_model(0)));
    chk("sig white", int'(s3), int'(sig_model(1)));
    chk("sig white repeat", int'(s4), int'(sig_model(1)));
`ifdef VGA_RX_SIG_EN
    chk("sig black vs white differ", int'(s1 != s3), 1);
`endif
    chk("locked before sync loss", int'(locked), 1);
    repeat (2000) drive(1'b1, 1'b1, 6'h00);
    chk("sync loss locked", int'(locked), 0);
    chk("sync loss err", int'(err), 1);
    chk("sync loss h_total_meas", int'(h_total_meas), 40);
    chk("invalid pixels zeroed", zero_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/vga_rx_monitor.md
Name: vga_rx_monitor

Overview:
- Receive-side counterpart of the VGA sync/pixel generator. It consumes the 8-bit TinyVGA PMOD bus and recovers sync timing, pixel coordinates and 6-bit colour.
- A lock FSM checks the recovered timing against 640x480@60 parameters.
- Used as an on-chip loopback checker: generator outputs drive `vga_in`. Measurements, lock state and an optional per-frame signature are exposed to the bench/host.

Parameters:
- H_TOTAL, 800: clocks per line (hsync fall to hsync fall).
- H_SYNC, 96: expected hsync low width in clocks.
- H_ACT_START, 144: `h_cnt` value of pixel x=0.
- H_ACTIVE, 640: active pixels per line.
- V_TOTAL, 525: lines per frame.
- V_ACT_START, 34: `v_cnt` value of line y=0.
- V_ACTIVE, 480: active lines per frame.
- LOCK_FRAMES, 2: consecutive good frames needed to lock (1..3).

Ports:
- clk  in  1  pixel clock (25.175 MHz)
- rst_n  in  1  synchronous, active-low reset
- vga_in  in  8  PMOD bus {hsync, b[0], g[0], r[0], vsync, b[1], g[1], r[1]}; syncs active-low
- pix_valid  out  1  recovered pixel is inside the active window
- pix_x  out  10  recovered x, 0..639
- pix_y  out  10  recovered y, 0..479
- rgb  out  6  {r[1:0], g[1:0], b[1:0]} of current pixel
- locked  out  1  timing locked
- frame_done  out  1  one-cycle pulse at each frame boundary (vsync fall)
- h_total_meas  out  10  last measured line length
- h_sync_meas  out  7  last measured hsync low width
- v_total_meas  out  10  last measured lines per frame
- err  out  1  sticky: lock lost; cleared only by reset
- frame_sig  out  16  signature of last complete frame

Behaviour:
- Input stage: `vga_in` registered once, giving `hs_q`/`vs_q`/colour. A second register holds the previous `hs_q`/`vs_q` for edge detection. All outputs derive from the registered copy.
  - Fixed latency from `vga_in` to `pix_*`/`rgb`: 2 clk.
- Horizontal counting:
  - `h_cnt` is 10 bits. It becomes 0 on the cycle `hs_q` first shows low (falling edge), else increments, saturating at 1023.
  - At each hsync fall: `h_total_meas <= h_cnt + 1`, unless the fall is the first after reset.
  - At each hsync rise: `h_sync_meas <=` low width in clocks, saturating at 127.
- Vertical counting:
  - A vsync fall sets `vs_pend`.
  - At the next hsync fall with `vs_pend` set: `v_total_meas <= v_cnt + 1`, `v_cnt <= 0`, `vs_pend` cleared.
  - Otherwise each hsync fall increments `v_cnt`, saturating at 1023.
- Pixel recovery:
  - `pix_valid = (H_ACT_START <= h_cnt < H_ACT_START+H_ACTIVE) && (V_ACT_START <= v_cnt < V_ACT_START+V_ACTIVE) && locked`.
  - `pix_x = h_cnt - H_ACT_START`; `pix_y = v_cnt - V_ACT_START`.
  - `pix_x`, `pix_y` and `rgb` are forced to 0 when `pix_valid` is low.
- `frame_done` pulses on the clock after a vsync fall is detected, independent of lock.
- Lock FSM, states SEARCH / MEASURE / LOCKED:
  - SEARCH: wait for vsync fall, then go to MEASURE with `good_cnt = 0`.
  - MEASURE: a frame is good if every line had line length = H_TOTAL and hsync width = H_SYNC, and the frame had lines = V_TOTAL.
    - On each frame boundary: good frame increments `good_cnt`; bad frame zeroes it.
    - Go to LOCKED when `good_cnt` reaches LOCK_FRAMES.
  - LOCKED: the first bad line length, hsync width or frame length returns the FSM to SEARCH, drops `locked` the next clock and sets `err`.
  - A line length is checked at the hsync fall that closes the line.
- Simultaneous vsync and hsync fall on one clock: the line closes first, then `vs_pend` is set. That line is counted in the current frame.
- Counter saturation (sync absent) forces the current frame bad. With sync absent in SEARCH, the FSM stays in SEARCH.
- Reset values:
  - All outputs 0, FSM in SEARCH, `vs_pend` = 0, `frame_sig` = 0.
  - Reset mid-frame discards partial measurements. The first post-reset edges do not update `*_meas`.

Optional Feature:
- Macro VGA_RX_SIG_EN.
- Defined:
  - CRC-16-CCITT (poly 0x1021, MSB-first) runs over `rgb` of every `pix_valid` pixel, 6 bits per clock.
  - The CRC is initialised to 0xFFFF at each frame boundary.
  - The final value is latched into `frame_sig` on the `frame_done` cycle, only if `locked` was high for the whole frame; otherwise `frame_sig` is held.
- Undefined: the CRC logic is absent and `frame_sig` is constant 0.

Test Plan:
- Ideal 800x525 timing, hsync low 96, vsync low 2 lines, after reset:
  - `h_total_meas` = 800, `h_sync_meas` = 96, `v_total_meas` = 525.
  - `locked` rises at the 2nd frame boundary after the first vsync fall.
  - `err` = 0.
- Locked, colour 6'b110100 driven only at generator pixel (0,0) -> `pix_valid` with `pix_x`=0, `pix_y`=0, `rgb`=6'b110100 exactly 2 clk after that input; no other valid pixel shows a nonzero colour.
- Locked, one line stretched to 801 clocks -> `locked` falls the clock after that line's closing hsync fall. `err` = 1 and stays 1 through 3 further good frames, while `locked` re-asserts after LOCK_FRAMES good frames.
- Hsync width 95 for 2 frames -> never locked, `h_sync_meas` = 95; width restored to 96 -> locked after 2 good frames.
- Hsync held high 2000 clocks -> `h_cnt` saturates, no lock. Reset asserted mid-line -> all outputs 0 next clock.
- VGA_RX_SIG_EN, all-black frame vs frame with one white pixel -> two different nonzero `frame_sig` values, each repeating identically on consecutive frames. Macro off -> `frame_sig` = 0.
